rf_write_arbiter: RTL
=====================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of write requesters sharing the register-file write port.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 srst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  NUM_REQ  per-requester write request valid.
REQ-005 req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-006 req_addr  input  NUM_REQ x 5  per-requester target register index.
REQ-007 req_data  input  NUM_REQ x 64  per-requester write data, bit order [0:63].
REQ-008 req_mask  input  NUM_REQ x 8  per-requester byte-enable, bit order [0:7].
REQ-009 reg_write  output  1  register-file write enable.
REQ-010 w_addr  output  5  register-file write address.
REQ-011 w_data  output  64  register-file write data.
REQ-012 r_addr1  output  5  register-file read address, used for read-modify-write.
REQ-013 r_data1  input  64  register-file read data; combinational from r_addr1.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 grant_id  output  2  index of the requester currently being serviced; valid while busy.

Function
REQ-016 FSM states: IDLE, READ, WRITE.
REQ-017 IDLE: if any req_valid is set, pick one round-robin, assert its req_ready that cycle, and latch its addr, data, mask and index.
REQ-018 Handshake completes on the cycle where valid and ready are both high; req_ready is asserted only in IDLE.
REQ-019 Accepted mask 8'hFF -> WRITE; mask 8'h00 -> remain IDLE, no write (request consumed and discarded); any other mask -> READ.
REQ-020 READ: drive r_addr1 = latched addr; at the clock edge, merge per byte: byte k (bits [8k:8k+7]) from latched data if mask[k]=1, else from r_data1; go to WRITE.
REQ-021 WRITE: reg_write=1 for exactly one cycle with w_addr = latched addr and w_data = merged/latched data; go to IDLE.
REQ-022 Latency from accept edge T: full mask -> reg_write high in cycle T+1; partial mask -> reg_write high in cycle T+2.
REQ-023 Round-robin: the search starts at pointer P (0 after reset), then P+1, ... wrapping modulo NUM_REQ; after a grant to i, P = (i+1) mod NUM_REQ.
REQ-024 P is unchanged when no request is accepted.
REQ-025 Outside READ, r_addr1 = 0; outside WRITE, reg_write = 0, w_addr = 0 and w_data = 0.
REQ-026 Requests that arrive while busy are held by the requester (valid stays high) and are never dropped by the arbiter.
REQ-027 A single requester with continuous valid gets one write per 2 cycles (full mask) or per 3 cycles (partial mask).

Reset
REQ-028 srst asserted forces, asynchronously: state=IDLE, P=0, req_ready=0, reg_write=0, busy=0, grant_id=0, r_addr1=0, w_addr=0, w_data=0.
REQ-029 Reset during READ or WRITE aborts the in-flight request with no register-file write; that request is not replayed.
REQ-030 The first accept can occur in the first cycle after srst deasserts.

Structure
REQ-031 Package rf_arb_pkg holds the state enum, ADDR_W=5, DATA_W=64, MASK_W=8 and a default NUM_REQ.
REQ-032 Round-robin selection is a sub-module rr_arbiter (inputs: valid vector and pointer; outputs: one-hot grant and index).

Verification
REQ-033 Requester 0: addr=3, data=64'h00000000000000FF, mask=FF -> reg_write high 1 cycle later, w_addr=3, w_data as given, req_ready[0] pulsed once.
REQ-034 Reg 5 preloaded with 64'h1111111111111111; write 64'hAAAAAAAAAAAAAAAA with mask=8'h0F -> r_addr1=5 in READ, then w_data=64'h11111111AAAAAAAA 2 cycles after accept.
REQ-035 All three requesters hold valid continuously -> grants occur in the order 0,1,2,0,1,2; no requester is granted twice before the others.
REQ-036 mask=8'h00 -> req_ready pulses, no reg_write, busy stays low, next request accepted the following cycle.
REQ-037 srst asserted while in WRITE -> reg_write drops immediately (before the clock edge), state=IDLE, P=0, no write to the register file.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types, widths and byte-merge helper for the register-file write arbiter.
// Data and mask vectors use ascending bit order: byte k of data is bits [8k:8k+7], enabled by mask[k].
package rf_arb_pkg;

    localparam int ADDR_W      = 5;
    localparam int DATA_W      = 64;
    localparam int MASK_W      = 8;
    localparam int DEF_NUM_REQ = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } arb_state_t;

    localparam logic [0:MASK_W-1] MASK_FULL = '1;
    localparam logic [0:MASK_W-1] MASK_NONE = '0;

    function automatic logic [0:DATA_W-1] merge_bytes(
        input logic [0:DATA_W-1] new_data,
        input logic [0:DATA_W-1] old_data,
        input logic [0:MASK_W-1] mask
    );
        logic [0:DATA_W-1] merged;
        merged = old_data;
        for (int k = 0; k < MASK_W; k++) begin
            if (mask[k]) begin
                merged[8*k +: 8] = new_data[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
// Zero latency; produces no grant when nothing is valid.
module rr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int cand;

    // Scan offsets from farthest to nearest so the nearest valid one wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (valid[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates NUM_REQ byte-masked writers onto one register-file write port, doing read-modify-write for partial masks.
// Full mask writes one cycle after accept, partial two; requesters are only accepted in IDLE and must hold valid while busy.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             clk,
    input  logic                             srst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][0:DATA_W-1]   req_data,
    input  logic [NUM_REQ-1:0][0:MASK_W-1]   req_mask,
    output logic                             reg_write,
    output logic [ADDR_W-1:0]                w_addr,
    output logic [0:DATA_W-1]                w_data,
    output logic [ADDR_W-1:0]                r_addr1,
    input  logic [0:DATA_W-1]                r_data1,
    output logic                             busy,
    output logic [IDX_W-1:0]                 grant_id
);

    arb_state_t          state;
    logic [IDX_W-1:0]    ptr;
    logic [ADDR_W-1:0]   lat_addr;
    logic [0:DATA_W-1]   lat_data;
    logic [0:MASK_W-1]   lat_mask;

    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    pick;
    logic                pick_any;
    logic [IDX_W-1:0]    ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (pick),
        .any   (pick_any)
    );

    // Gated by srst so no handshake can complete while reset is held.
    assign req_ready = (state == ST_IDLE && !srst) ? grant : '0;
    assign ptr_next  = (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + IDX_W'(1);

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_mask  <= '0;
            reg_write <= 1'b0;
            w_addr    <= '0;
            w_data    <= '0;
            r_addr1   <= '0;
            busy      <= 1'b0;
            grant_id  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        ptr      <= ptr_next;
                        grant_id <= pick;
                        lat_addr <= req_addr[pick];
                        lat_data <= req_data[pick];
                        lat_mask <= req_mask[pick];
                        if (req_mask[pick] == MASK_FULL) begin
                            state     <= ST_WRITE;
                            busy      <= 1'b1;
                            reg_write <= 1'b1;
                            w_addr    <= req_addr[pick];
                            w_data    <= req_data[pick];
                        end else if (req_mask[pick] != MASK_NONE) begin
                            state   <= ST_READ;
                            busy    <= 1'b1;
                            r_addr1 <= req_addr[pick];
                        end
                        // An all-zero mask is consumed here with no write.
                    end
                end
                ST_READ: begin
                    state     <= ST_WRITE;
                    r_addr1   <= '0;
                    reg_write <= 1'b1;
                    w_addr    <= lat_addr;
                    w_data    <= merge_bytes(lat_data, r_data1, lat_mask);
                end
                ST_WRITE: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    reg_write <= 1'b0;
                    w_addr    <= '0;
                    w_data    <= '0;
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    reg_write <= 1'b0;
                    r_addr1   <= '0;
                    w_addr    <= '0;
                    w_data    <= '0;
                end
            endcase
        end
    end

endmodule
